// File: rtl/hangman_guess_tracker.sv
// Hangman round tracker: evaluates one guessed letter per go press against
// the latched five-slot word and runs the play / win / lose state machine.
module hangman_guess_tracker #(
  parameter int unsigned MAX_WRONG  = 6,
  parameter logic [4:0]  DUMMY_CODE = 5'b11111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       new_game,
  input  logic [4:0] guess,
  input  logic [4:0] letter1,
  input  logic [4:0] letter2,
  input  logic [4:0] letter3,
  input  logic [4:0] letter4,
  input  logic [4:0] letter5,
  output logic [4:0] revealed,
  output logic [3:0] wrong_count,
  output logic       last_hit,
  output logic       last_repeat,
  output logic       last_invalid,
  output logic       ready,
  output logic       win,
  output logic       lose
);

  localparam int unsigned SLOTS = 5;
  localparam int unsigned LW    = 5;
  localparam int unsigned NLET  = 26;
  localparam int unsigned CW    = 4;

  localparam logic [CW-1:0] MAX_WRONG_C = CW'(MAX_WRONG);
  localparam logic [LW-1:0] LAST_LETTER = LW'(NLET - 1);

  localparam logic [2:0] S_READY   = 3'd0;
  localparam logic [2:0] S_EVAL    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_WIN     = 3'd3;
  localparam logic [2:0] S_LOSE    = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [SLOTS-1:0][LW-1:0]    word_q, word_d;
  logic [LW-1:0]               guess_q, guess_d;
  logic [SLOTS-1:0]            revealed_q, revealed_d;
  logic [CW-1:0]               wrong_q, wrong_d;
  logic [NLET-1:0]             used_q, used_d;
  logic                        hit_q, hit_d;
  logic                        rep_q, rep_d;
  logic                        inv_q, inv_d;

  logic [SLOTS-1:0][LW-1:0]    letters_in;
  logic [SLOTS-1:0]            needed;
  logic [SLOTS-1:0]            match;
  logic                        complete;
  logic                        guess_valid;
  logic [NLET-1:0]             guess_onehot;
  logic                        is_repeat;

  assign letters_in = {letter5, letter4, letter3, letter2, letter1};

  // Slot bookkeeping: which slots count toward a win and which match the held guess.
  always_comb begin
    needed = '0;
    match  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      needed[i] = (word_q[i] != DUMMY_CODE);
      match[i]  = (word_q[i] == guess_q) && needed[i];
    end
  end

  assign complete     = ((revealed_q & needed) == needed);
  assign guess_valid  = (guess_q <= LAST_LETTER);
  assign guess_onehot = NLET'(1) << guess_q;
  assign is_repeat    = |(used_q & guess_onehot);

  // Next-state and datapath update; new_game overrides everything.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    guess_d    = guess_q;
    revealed_d = revealed_q;
    wrong_d    = wrong_q;
    used_d     = used_q;
    hit_d      = hit_q;
    rep_d      = rep_q;
    inv_d      = inv_q;

    case (state_q)
      S_READY: begin
        if (complete) begin
          state_d = S_WIN;
        end else if (go) begin
          guess_d = guess;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        state_d = S_RELEASE;
        if (!guess_valid) begin
          inv_d = 1'b1;
          hit_d = 1'b0;
          rep_d = 1'b0;
        end else if (is_repeat) begin
          rep_d = 1'b1;
          hit_d = 1'b0;
          inv_d = 1'b0;
        end else if (|match) begin
          revealed_d = revealed_q | match;
          used_d     = used_q | guess_onehot;
          hit_d      = 1'b1;
          rep_d      = 1'b0;
          inv_d      = 1'b0;
        end else begin
          if (wrong_q < MAX_WRONG_C) begin
            wrong_d = wrong_q + CW'(1);
          end
          used_d = used_q | guess_onehot;
          hit_d  = 1'b0;
          rep_d  = 1'b0;
          inv_d  = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!go) begin
          if (complete) begin
            state_d = S_WIN;
          end else if (wrong_q >= MAX_WRONG_C) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_READY;
          end
        end
      end
      S_WIN, S_LOSE: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_READY;
      end
    endcase

    if (new_game) begin
      state_d    = S_READY;
      word_d     = letters_in;
      guess_d    = '0;
      revealed_d = '0;
      wrong_d    = '0;
      used_d     = '0;
      hit_d      = 1'b0;
      rep_d      = 1'b0;
      inv_d      = 1'b0;
    end
  end

  // State and datapath registers; reset also latches the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_READY;
      word_q     <= letters_in;
      guess_q    <= '0;
      revealed_q <= '0;
      wrong_q    <= '0;
      used_q     <= '0;
      hit_q      <= 1'b0;
      rep_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      guess_q    <= guess_d;
      revealed_q <= revealed_d;
      wrong_q    <= wrong_d;
      used_q     <= used_d;
      hit_q      <= hit_d;
      rep_q      <= rep_d;
      inv_q      <= inv_d;
    end
  end

  assign revealed     = revealed_q;
  assign wrong_count  = wrong_q;
  assign last_hit     = hit_q;
  assign last_repeat  = rep_q;
  assign last_invalid = inv_q;
  assign ready        = (state_q == S_READY);
  assign win          = (state_q == S_WIN);
  assign lose         = (state_q == S_LOSE);

endmodule

// File: tb/tb_hangman_guess_tracker.sv
// Self-checking bench for hangman_guess_tracker using a reference model and
// a scoreboard of expected post-evaluation and post-release results.
module tb_hangman_guess_tracker;

  localparam int unsigned MAX_WRONG = 6;

  logic       clk = 1'b0;
  logic       reset, go, new_game;
  logic [4:0] guess, letter1, letter2, letter3, letter4, letter5;
  logic [4:0] revealed;
  logic [3:0] wrong_count;
  logic       last_hit, last_repeat, last_invalid, ready, win, lose;

  hangman_guess_tracker #(.MAX_WRONG(MAX_WRONG), .DUMMY_CODE(5'b11111)) dut (
    .clk(clk), .reset(reset), .go(go), .new_game(new_game), .guess(guess),
    .letter1(letter1), .letter2(letter2), .letter3(letter3),
    .letter4(letter4), .letter5(letter5),
    .revealed(revealed), .wrong_count(wrong_count), .last_hit(last_hit),
    .last_repeat(last_repeat), .last_invalid(last_invalid),
    .ready(ready), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rev;
    logic [3:0] wc;
    logic       hit;
    logic       rep;
    logic       inv;
  } eval_exp_t;

  eval_exp_t  eval_q[$];
  logic [2:0] state_q[$];  // {ready, win, lose}

  int checks   = 0;
  int failures = 0;

  logic [4:0]  m_word [5];
  logic [4:0]  m_rev;
  int          m_wc;
  logic [25:0] m_used;
  logic [2:0]  m_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_underflow(input string tag);
    checks++;
    failures++;
    $display("FAIL %s: scoreboard empty at %0t", tag, $time);
  endtask

  task automatic model_load(input logic [4:0] w0, w1, w2, w3, w4);
    m_word[0] = w0; m_word[1] = w1; m_word[2] = w2; m_word[3] = w3; m_word[4] = w4;
    m_rev = '0; m_wc = 0; m_used = '0; m_state = 3'b100;
  endtask

  // Reference behaviour of one evaluation plus the following release decision.
  task automatic model_eval(input logic [4:0] g);
    eval_exp_t  e;
    logic [4:0] mt, nd;
    e = '0;
    mt = '0; nd = '0;
    for (int i = 0; i < 5; i++) begin
      nd[i] = (m_word[i] != 5'd31);
      mt[i] = nd[i] && (m_word[i] == g);
    end
    if (g > 5'd25) begin
      e.inv = 1'b1;
    end else if (m_used[g]) begin
      e.rep = 1'b1;
    end else if (mt != 0) begin
      m_rev = m_rev | mt; m_used[g] = 1'b1; e.hit = 1'b1;
    end else begin
      m_wc++; m_used[g] = 1'b1;
    end
    e.rev = m_rev;
    e.wc  = 4'(m_wc);
    eval_q.push_back(e);
    if ((m_rev & nd) == nd)   m_state = 3'b010;
    else if (m_wc >= int'(MAX_WRONG)) m_state = 3'b001;
    else                      m_state = 3'b100;
    state_q.push_back(m_state);
  endtask

  task automatic press(input logic [4:0] g, input int hold);
    eval_exp_t  e;
    logic [2:0] s;
    guess = g; go = 1'b1;
    model_eval(g);
    @(negedge clk);
    guess = g ^ 5'h1f;  // must be ignored after the capture edge
    @(negedge clk);
    if (eval_q.size() == 0) sb_underflow("eval");
    else begin
      e = eval_q.pop_front();
      check("revealed", 32'(revealed), 32'(e.rev));
      check("wrong_count", 32'(wrong_count), 32'(e.wc));
      check("last_hit", 32'(last_hit), 32'(e.hit));
      check("last_repeat", 32'(last_repeat), 32'(e.rep));
      check("last_invalid", 32'(last_invalid), 32'(e.inv));
    end
    for (int i = 2; i < hold; i++) begin
      check("held_ready", 32'(ready), 32'(0));
      @(negedge clk);
    end
    go = 1'b0;
    @(negedge clk);
    if (state_q.size() == 0) sb_underflow("state");
    else begin
      s = state_q.pop_front();
      check("rdy_win_lose", 32'({ready, win, lose}), 32'(s));
      check("revealed_post", 32'(revealed), 32'(m_rev));
      check("wrong_post", 32'(wrong_count), 32'(m_wc));
    end
  endtask

  // go in a terminal state must change nothing.
  task automatic idle_press();
    go = 1'b1; guess = 5'd7;
    repeat (3) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("term_state", 32'({ready, win, lose}), 32'(m_state));
    check("term_revealed", 32'(revealed), 32'(m_rev));
    check("term_wrong", 32'(wrong_count), 32'(m_wc));
  endtask

  task automatic start_game(input logic [4:0] w0, w1, w2, w3, w4);
    letter1 = w0; letter2 = w1; letter3 = w2; letter4 = w3; letter5 = w4;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    letter1 = 5'd9; letter2 = 5'd9; letter3 = 5'd9; letter4 = 5'd9; letter5 = 5'd9;
    model_load(w0, w1, w2, w3, w4);
    check("ng_ready", 32'(ready), 32'(1));
    check("ng_wrong", 32'(wrong_count), 32'(0));
    check("ng_revealed", 32'(revealed), 32'(0));
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; new_game = 1'b0; guess = '0;
    letter1 = 5'd18; letter2 = 5'd19; letter3 = 5'd0; letter4 = 5'd24; letter5 = 5'd31;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    letter1 = 5'd9;
    model_load(5'd18, 5'd19, 5'd0, 5'd24, 5'd31);
    check("rst_outputs", 32'({revealed, wrong_count, last_hit, last_repeat, last_invalid}), 32'(0));
    check("rst_state", 32'({ready, win, lose}), 32'(3'b100));

    // Hit, miss, repeat, invalid, then win with a long final press.
    press(5'd18, 2);
    press(5'd25, 2);
    press(5'd25, 3);
    press(5'd30, 2);
    press(5'd19, 2);
    press(5'd0, 2);
    press(5'd24, 5);
    check("win_revealed", 32'(revealed), 32'(5'b01111));
    idle_press();

    // Six distinct misses end the round.
    start_game(5'd18, 5'd19, 5'd0, 5'd24, 5'd31);
    for (int g = 1; g <= 6; g++) press(5'(g), 2);
    check("lose_flag", 32'(lose), 32'(1));
    check("lose_wrong", 32'(wrong_count), 32'(6));
    idle_press();

    // new_game lands on the evaluation edge of a pending miss.
    start_game(5'd18, 5'd19, 5'd0, 5'd24, 5'd31);
    press(5'd25, 2);
    guess = 5'd7; go = 1'b1;
    @(negedge clk);
    letter1 = 5'd1; letter2 = 5'd2; letter3 = 5'd3; letter4 = 5'd31; letter5 = 5'd31;
    new_game = 1'b1; go = 1'b0;
    @(negedge clk);
    new_game = 1'b0;
    model_load(5'd1, 5'd2, 5'd3, 5'd31, 5'd31);
    check("mid_wrong", 32'(wrong_count), 32'(0));
    check("mid_revealed", 32'(revealed), 32'(0));
    check("mid_state", 32'({ready, win, lose}), 32'(3'b100));
    check("mid_flags", 32'({last_hit, last_repeat, last_invalid}), 32'(0));
    press(5'd25, 2);  // used set was cleared, so this is a fresh miss
    press(5'd1, 2);   // hit in the newly loaded word

    // All-dummy word wins without any guess.
    start_game(5'd31, 5'd31, 5'd31, 5'd31, 5'd31);
    @(negedge clk);
    check("dummy_win", 32'({ready, win, lose}), 32'(3'b010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hangman_guess_tracker.md
Name: hangman_guess_tracker

Overview:
- Downstream consumer of the per-letter compare/enable stage of the Hangman game.
- Takes one 5-bit guessed letter per `go` press and compares it against the latched 5-slot word.
- Keeps the revealed-position mask, the wrong-guess count and the set of already-used letters.
- Runs the round state machine (play / win / lose) that drives the HEX and LEDR display logic.

Parameters:
- MAX_WRONG, 6, number of wrong guesses that ends the round in LOSE. Legal range 1..15.
- DUMMY_CODE, 5'b11111, letter code that marks an unused word slot. It never counts toward a win and never matches.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  guess strobe, level; a press is one high period.
- new_game  input  1  synchronous restart; reloads the word and clears progress.
- guess  input  5  guessed letter code; A=0 .. Z=25; values 26..31 are invalid.
- letter1..letter5  input  5 each  word slot codes; letter1 is the leftmost slot.
- revealed  output  5  bit i-1 is set when slot letter_i has been guessed.
- wrong_count  output  4  number of wrong, non-repeat, valid guesses this round.
- last_hit  output  1  the last evaluated guess matched at least one slot.
- last_repeat  output  1  the last evaluated guess had already been used.
- last_invalid  output  1  the last evaluated guess code was greater than 25.
- ready  output  1  high in S_READY; a guess is accepted now.
- win  output  1  high in S_WIN.
- lose  output  1  high in S_LOSE.

Behaviour:
- Reset and new_game
  - On reset or new_game, at the same edge: word_q[1..5] loads from letter1..letter5.
  - revealed, wrong_count, used_set[25:0] and all last_* flags clear to 0.
  - State goes to S_READY.
  - new_game has priority over every other event, including go and an in-progress S_EVAL.
  - After reset: ready=1; all other outputs 0.
- Derived signals
  - needed[i] = (word_q[i] != DUMMY_CODE).
  - complete = ((revealed & needed) == needed).
  - match[i] = (word_q[i] == guess_q) and needed[i].
- State S_READY
  - If complete, go to S_WIN. This covers an all-dummy word; complete is checked before go.
  - Otherwise, if go is sampled 1: guess_q <= guess and go to S_EVAL.
  - Otherwise stay.
- State S_EVAL (exactly 1 cycle), always goes to S_RELEASE. Updates at this edge:
  - Invalid (guess_q > 25): last_invalid=1, last_hit=0, last_repeat=0. No other change.
  - Repeat (used_set[guess_q]=1): last_repeat=1, last_hit=0, last_invalid=0. revealed and wrong_count unchanged.
  - New hit (match != 0): revealed <= revealed | match; used_set[guess_q] <= 1; last_hit=1; other flags 0.
  - New miss: wrong_count <= wrong_count + 1; used_set[guess_q] <= 1; all last_* flags 0.
- State S_RELEASE
  - Wait while go is 1.
  - When go is sampled 0: go to S_WIN if complete, else S_LOSE if wrong_count >= MAX_WRONG, else S_READY.
  - win takes precedence if both conditions hold; this cannot arise from a single guess, but the order is fixed.
- States S_WIN / S_LOSE
  - Terminal; go is ignored. Exit only via new_game or reset.
  - revealed and wrong_count hold their values for display.
- Latency
  - go sampled high at edge E0 (in S_READY) gives state=S_EVAL after E0.
  - revealed, wrong_count and last_* update at E1.
  - win/lose/ready update at the first edge after E1 where go is sampled low; at the earliest this is E2.
- Outputs are all registered or state-decoded (Moore); no combinational path from inputs to outputs.
- Holding go high for N cycles yields exactly one evaluation.
- wrong_count never exceeds MAX_WRONG.
- guess is sampled only at the S_READY→S_EVAL edge; changes at any other time are ignored.
- letter inputs are sampled only at reset/new_game; changes mid-round are ignored.

Test Plan:
- Hit: word S,T,A,Y,dummy (18,19,0,24,31); press go with guess=18 → after E1: revealed=5'b00001, last_hit=1, wrong_count=0; after release: ready=1.
- Miss then repeat: guess=25 → wrong_count=1, last_hit=0. guess=25 again → last_repeat=1, wrong_count stays 1, revealed unchanged.
- Win and long press: guesses 18,19,0 then 24, with go held 5 cycles on the last → single evaluation; revealed=5'b01111; win=1 on the edge after go falls; further go presses have no effect.
- Lose and invalid: six distinct misses (1,2,3,4,5,6) → lose=1 after the sixth release with wrong_count=6. Separately, guess=30 in play → last_invalid=1, wrong_count unchanged.
- new_game mid-evaluation: new_game=1 on the same edge as S_EVAL with a miss pending → wrong_count=0, revealed=0, used_set cleared, ready=1. A new word loaded from the letter inputs is in effect.
- All-dummy word: load 31,31,31,31,31 via new_game → win=1 one cycle later with no guesses made.
